// File: rtl/wb_cmd_decoder.sv
// Frames UART bytes into 34-bit {sub, data} command words for the Wishbone master,
// flagging bad headers, inter-byte timeouts and overruns.
module wb_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_byte,
    output logic        o_cmd_stb,
    output logic [33:0] o_cmd_word,
    input  logic        i_cmd_busy,
    output logic        o_frame_err,
    output logic        o_overrun,
    output logic [7:0]  o_err_count
);

    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 8;
    // Last counter value before the timeout fires; the error pulse then lands
    // exactly TIMEOUT_CYCLES cycles after the last byte.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [5:0]       HDR_TAG  = 6'b101000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sub_q, sub_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                cmd_stb_d;
    logic [33:0]         cmd_word_d;
    logic                frame_err_d;
    logic                overrun_d;
    logic [CNT_W-1:0]    err_count_d;

    logic                hdr_ok;
    logic                take_hdr;

    assign hdr_ok = (i_rx_byte[7:2] == HDR_TAG);

    // A byte is decoded as a header in IDLE, or in HOLD on the transfer cycle.
    assign take_hdr = i_rx_stb &&
                      ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && !i_cmd_busy));

    // State register and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            sub_q       <= 2'd0;
            data_q      <= '0;
            byte_cnt_q  <= 2'd0;
            tmo_cnt_q   <= '0;
            o_cmd_stb   <= 1'b0;
            o_cmd_word  <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_err_count <= '0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            data_q      <= data_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            o_cmd_stb   <= cmd_stb_d;
            o_cmd_word  <= cmd_word_d;
            o_frame_err <= frame_err_d;
            o_overrun   <= overrun_d;
            o_err_count <= err_count_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        data_d      = data_q;
        byte_cnt_d  = byte_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        cmd_stb_d   = o_cmd_stb;
        cmd_word_d  = o_cmd_word;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        err_count_d = o_err_count;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_PAYLOAD: begin
                if (i_rx_stb) begin
                    data_d     = {data_q[DATA_W-9:0], i_rx_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    tmo_cnt_d  = '0;
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = ST_HOLD;
                        cmd_stb_d  = 1'b1;
                        cmd_word_d = {sub_q, data_q[DATA_W-9:0], i_rx_byte};
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_HOLD: begin
                if (!i_cmd_busy) begin
                    state_d   = ST_IDLE;
                    cmd_stb_d = 1'b0;
                end else if (i_rx_stb) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cmd_stb_d = 1'b0;
            end
        endcase

        // Header decode shared by IDLE and the HOLD transfer cycle.
        if (take_hdr) begin
            if (hdr_ok) begin
                sub_d = i_rx_byte[1:0];
                if (i_rx_byte[1:0] == 2'b00) begin
                    state_d    = ST_HOLD;
                    cmd_stb_d  = 1'b1;
                    cmd_word_d = '0;
                end else begin
                    state_d    = ST_PAYLOAD;
                    byte_cnt_d = 2'd0;
                    tmo_cnt_d  = '0;
                    data_d     = '0;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end

        if ((frame_err_d || overrun_d) && (o_err_count != 8'hFF)) begin
            err_count_d = o_err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_wb_cmd_decoder.sv
// Bench for wb_cmd_decoder: directed frames from the test plan plus random byte
// traffic checked cycle by cycle against a frame-level reference model.
module tb_wb_cmd_decoder;

    localparam int unsigned TMO = 16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_rx_stb;
    logic [7:0]  i_rx_byte;
    logic        o_cmd_stb;
    logic [33:0] o_cmd_word;
    logic        i_cmd_busy;
    logic        o_frame_err;
    logic        o_overrun;
    logic [7:0]  o_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pending word, bytes of the frame being collected,
    // idle cycles since the last byte, expected pulses and error total.
    bit          m_pending;
    logic [33:0] m_word;
    logic [7:0]  m_frame[$];
    int          m_silence;
    bit          m_ferr;
    bit          m_ovr;
    int          m_errs;

    wb_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_stb    (i_rx_stb),
        .i_rx_byte   (i_rx_byte),
        .o_cmd_stb   (o_cmd_stb),
        .o_cmd_word  (o_cmd_word),
        .i_cmd_busy  (i_cmd_busy),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_err_count (o_err_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pending = 1'b0;
        m_word    = '0;
        m_frame.delete();
        m_silence = 0;
        m_ferr    = 1'b0;
        m_ovr     = 1'b0;
        m_errs    = 0;
    endtask

    // One clock of the model, from the frame rules rather than a state machine.
    task automatic model_step(input bit stb, input logic [7:0] b, input bit busy);
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        if (m_pending && !busy) m_pending = 1'b0;
        if (m_frame.size() > 0) begin
            if (stb) begin
                m_frame.push_back(b);
                m_silence = 0;
                if (m_frame.size() == 5) begin
                    m_word = {m_frame[0][1:0], m_frame[1], m_frame[2], m_frame[3], m_frame[4]};
                    m_pending = 1'b1;
                    m_frame.delete();
                end
            end else begin
                m_silence++;
                if (m_silence == int'(TMO) - 1) begin
                    m_ferr = 1'b1;
                    m_frame.delete();
                end
            end
        end else if (stb) begin
            if (m_pending) begin
                m_ovr = 1'b1;
            end else if (b >= 8'hA0 && b <= 8'hA3) begin
                if (b == 8'hA0) begin
                    m_pending = 1'b1;
                    m_word    = '0;
                end else begin
                    m_frame.push_back(b);
                    m_silence = 0;
                end
            end else begin
                m_ferr = 1'b1;
            end
        end
        if ((m_ferr || m_ovr) && m_errs < 255) m_errs++;
    endtask

    task automatic compare_all();
        check("cmd_stb", o_cmd_stb, m_pending);
        if (m_pending) check("cmd_word", o_cmd_word, m_word);
        check("frame_err", o_frame_err, m_ferr);
        check("overrun", o_overrun, m_ovr);
        check("err_count", o_err_count, m_errs);
    endtask

    task automatic cycle(input bit stb, input logic [7:0] b, input bit busy);
        i_rx_stb   = stb;
        i_rx_byte  = b;
        i_cmd_busy = busy;
        model_step(stb, b, busy);
        @(posedge i_clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        i_reset    = 1'b1;
        i_rx_stb   = 1'b0;
        i_rx_byte  = 8'h00;
        i_cmd_busy = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        model_clear();
        check("rst_stb", o_cmd_stb, 0);
        check("rst_word", o_cmd_word, 0);
        check("rst_ferr", o_frame_err, 0);
        check("rst_ovr", o_overrun, 0);
        check("rst_cnt", o_err_count, 0);
    endtask

    logic [7:0] rb;

    initial begin
        i_reset    = 1'b1;
        i_rx_stb   = 1'b0;
        i_rx_byte  = 8'h00;
        i_cmd_busy = 1'b0;
        model_clear();
        repeat (2) @(posedge i_clk);
        do_reset();

        // Write frame: strobe for exactly one cycle after the last byte.
        cycle(1, 8'hA1, 0); cycle(1, 8'h12, 0); cycle(1, 8'h34, 0); cycle(1, 8'h56, 0);
        cycle(1, 8'h78, 0);
        check("wr_stb", o_cmd_stb, 1);
        check("wr_word", o_cmd_word, 34'h1_1234_5678);
        cycle(0, 8'h00, 0);
        check("wr_stb_drop", o_cmd_stb, 0);

        // Read then address frame.
        cycle(1, 8'hA0, 0);
        check("rd_stb", o_cmd_stb, 1);
        check("rd_word", o_cmd_word, 34'h0);
        cycle(0, 8'h00, 0);
        cycle(1, 8'hA2, 0); cycle(1, 8'h00, 0); cycle(1, 8'h00, 0); cycle(1, 8'h00, 0);
        cycle(1, 8'h05, 0);
        check("adr_word", o_cmd_word, 34'h2_0000_0005);
        cycle(0, 8'h00, 0);
        check("adr_cnt", o_err_count, 0);

        // Bad header followed by a read.
        do_reset();
        cycle(1, 8'h55, 0);
        check("bad_ferr", o_frame_err, 1);
        check("bad_nostb", o_cmd_stb, 0);
        cycle(1, 8'hA0, 0);
        check("bad_ferr_1cyc", o_frame_err, 0);
        check("bad_rd_word", o_cmd_word, 34'h0);
        check("bad_cnt", o_err_count, 1);
        cycle(0, 8'h00, 0);

        // Timeout: error exactly TMO cycles after the last payload byte.
        do_reset();
        cycle(1, 8'hA1, 0); cycle(1, 8'hDE, 0); cycle(1, 8'hAD, 0);
        for (int i = 0; i < int'(TMO) - 2; i++) cycle(0, 8'h00, 0);
        check("tmo_early", o_frame_err, 0);
        cycle(0, 8'h00, 0);
        check("tmo_ferr", o_frame_err, 1);
        check("tmo_nostb", o_cmd_stb, 0);
        cycle(1, 8'hA0, 0);
        check("tmo_rd_stb", o_cmd_stb, 1);
        check("tmo_rd_word", o_cmd_word, 34'h0);
        cycle(0, 8'h00, 0);

        // Busy master: overrun keeps the held word, then one transfer.
        do_reset();
        cycle(1, 8'hA1, 1); cycle(1, 8'hCA, 1); cycle(1, 8'hFE, 1); cycle(1, 8'hBA, 1);
        cycle(1, 8'hBE, 1);
        for (int i = 0; i < 20; i++) begin
            cycle(i == 5, 8'hA0, 1);
            if (i == 5) check("busy_ovr", o_overrun, 1);
        end
        check("busy_word", o_cmd_word, 34'h1_CAFE_BABE);
        check("busy_stb", o_cmd_stb, 1);
        check("busy_cnt", o_err_count, 1);
        cycle(0, 8'h00, 0);
        check("busy_xfer_done", o_cmd_stb, 0);

        // Reset mid-frame discards the partial frame silently.
        cycle(1, 8'hA3, 0); cycle(1, 8'h11, 0); cycle(1, 8'h22, 0);
        do_reset();
        cycle(1, 8'hA0, 0);
        check("rst_rd_word", o_cmd_word, 34'h0);
        check("rst_rd_stb", o_cmd_stb, 1);
        check("rst_rd_cnt", o_err_count, 0);
        cycle(0, 8'h00, 0);

        // Random traffic including back-to-back reads, timeouts and saturation.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                for (int j = 0; j < 20; j++) cycle(0, 8'h00, $urandom_range(0, 99) < 30);
            end else begin
                case ($urandom_range(0, 3))
                    0:       rb = 8'hA0;
                    1:       rb = 8'hA0 | 8'($urandom_range(0, 3));
                    default: rb = 8'($urandom);
                endcase
                cycle($urandom_range(0, 99) < 45, rb, $urandom_range(0, 99) < 30);
            end
        end
        check("rand_cnt_sat", o_err_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cmd_decoder.md
# wb_cmd_decoder

Byte-to-command framer that sits directly upstream of the Wishbone bus master. It consumes the byte stream from the UART receiver and assembles framed host commands into 34-bit command words: `{sub[1:0], data[31:0]}`. It presents each word to the master with a strobe/busy handshake. It also detects malformed frames, inter-byte timeouts and overruns.

## Interface
Parameters
- `TIMEOUT_CYCLES`, default 100000: idle cycles allowed between payload bytes before the partial frame is discarded. Minimum 2.

Ports
- `i_clk`  in  1  system clock; all logic on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_rx_stb`  in  1  one-cycle pulse: `i_rx_byte` valid. The UART receiver cannot be stalled.
- `i_rx_byte`  in  8  received byte.
- `o_cmd_stb`  out  1  command word pending; level, held until accepted.
- `o_cmd_word`  out  34  `{sub, data}`; stable while `o_cmd_stb`=1.
- `i_cmd_busy`  in  1  master busy; a transfer occurs on a cycle with `o_cmd_stb`=1 and `i_cmd_busy`=0.
- `o_frame_err`  out  1  one-cycle pulse: bad header byte or payload timeout.
- `o_overrun`  out  1  one-cycle pulse: byte dropped because a word was still pending.
- `o_err_count`  out  8  saturating count of `o_frame_err` plus `o_overrun` events.

## Operation
- Frame format: a header byte, then 0 or 4 payload bytes.
  - Header bits [7:2] must equal 6'b101000, so valid headers are 0xA0–0xA3. Bits [1:0] give `sub`: 00 = read, 01 = write, 10 = address, 11 = special.
  - Read (0xA0) has no payload and produces data = 0.
  - Write, address and special each carry 4 payload bytes, MSB first: data = {b0, b1, b2, b3}.
- States:
  - IDLE:
    - On `i_rx_stb` with a valid header, latch `sub`.
    - If sub = 00, go to HOLD with data = 0. Otherwise clear the byte counter and go to PAYLOAD.
    - On `i_rx_stb` with an invalid header, pulse `o_frame_err` and stay in IDLE.
  - PAYLOAD:
    - Each `i_rx_stb` shifts the byte into data[7:0] (data <<= 8), increments the byte counter and clears the timeout counter.
    - On the 4th byte, go to HOLD.
    - The timeout counter increments on cycles without `i_rx_stb`. When it reaches `TIMEOUT_CYCLES`-1, discard the frame, pulse `o_frame_err` and go to IDLE.
  - HOLD:
    - `o_cmd_stb`=1. On the transfer cycle, go to IDLE.
    - If `i_rx_stb` coincides with the transfer cycle, the byte is processed exactly as in IDLE: header decode, or error. Nothing is lost.
    - If `i_rx_stb` arrives while `i_cmd_busy`=1, the byte is dropped and `o_overrun` pulses. `o_cmd_word` is unchanged.
- `o_err_count` increments once per cycle in which `o_frame_err` or `o_overrun` is 1. It saturates at 255 and clears only on reset.
- Timeout counter width is $clog2(`TIMEOUT_CYCLES`). The counter is cleared on entry to PAYLOAD.

## Timing
- Reset values: `o_cmd_stb`=0, `o_cmd_word`=0, `o_frame_err`=0, `o_overrun`=0, `o_err_count`=0, state = IDLE, all counters 0. A reset mid-frame or mid-HOLD discards everything, with no error pulse.
- All outputs are registered.
- Latency:
  - Read header accepted at cycle N: `o_cmd_stb`=1 from N+1.
  - 4th payload byte at cycle M: `o_cmd_stb`=1 from M+1.
- Transfer at cycle T (`o_cmd_stb` & !`i_cmd_busy`): `o_cmd_stb`=0 at T+1. If a read header also arrived at T, `o_cmd_stb`=1 again at T+1 with the new word, i.e. a back-to-back transfer.
- `o_cmd_word` may change only on the cycle after a transfer or on reset.
- Error pulses assert on the cycle after the causing event and last exactly one cycle.
- Timeout: with the last payload byte at cycle K and no further bytes, `o_frame_err`=1 at K+`TIMEOUT_CYCLES`.

## Test plan
- Write frame: bytes A1 12 34 56 78, `i_cmd_busy`=0 → `o_cmd_stb` high for exactly 1 cycle, one cycle after 0x78, with `o_cmd_word`=34'h1_1234_5678.
- Read frame: A0 → `o_cmd_word`=34'h0_0000_0000. Then address frame A2 00 00 00 05 → 34'h2_0000_0005. No error pulses, `o_err_count`=0.
- Bad header: 0x55, then A0 → one `o_frame_err` pulse, no strobe for 0x55. The read word is produced normally and `o_err_count`=1.
- Timeout (`TIMEOUT_CYCLES`=16): A1 DE AD, then silence → `o_frame_err` 16 cycles after 0xAD, no strobe. A following A0 produces 34'h0.
- Busy: write A1 CA FE BA BE with `i_cmd_busy`=1 for 20 cycles; send 0xA0 during busy → `o_overrun` pulse, word stays 34'h1_CAFE_BABE. Release busy → single transfer.
- Reset: assert `i_reset` after A3 11 22, then send A0 → all outputs at reset values, a clean read word, `o_err_count`=0.
